// File: rtl/spu_pcx_req_ctl.sv
// Round-robin arbiter and request sequencer for the SPU->LSU PCX packet register.
// Optional watchdog guarded by SPU_PCX_TIMEOUT_EN (spu_pcx_timeout tied to 0 otherwise).
module spu_pcx_req_ctl #(
    parameter int NREQ      = 4,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic [NREQ-1:0]  spu_req_vld,
    output logic [NREQ-1:0]  spu_req_grant,
    output logic             spu_wen_pcx_wen,
    output logic             spu_wen_pcx_7170_sel,
    output logic             spu_lsu_ldst_req,
    input  logic             lsu_spu_ldst_ack,
    input  logic             lsu_spu_ldst_ret,
    output logic [CNT_W-1:0] spu_pcx_outst_cnt,
    output logic             spu_pcx_busy,
    output logic             spu_pcx_timeout
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               can_grant;
    logic               ret_eff;
    logic [CNT_W-1:0]   next_cnt;
    int                 idx;

    // Rotating search starting at the pointer; first requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && spu_req_vld[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    // Reset gates the grant so a request held through reset cannot pulse the enables.
    assign can_grant = !reset && found
                       && (spu_pcx_outst_cnt < CNT_W'(MAX_OUTST))
                       && ((state == IDLE) || lsu_spu_ldst_ack);

    assign spu_req_grant        = can_grant ? (NREQ'(1) << winner) : '0;
    assign spu_wen_pcx_wen      = can_grant;
    assign spu_wen_pcx_7170_sel = can_grant;
    assign spu_lsu_ldst_req     = (state == REQ);

    assign ret_eff = lsu_spu_ldst_ret && (spu_pcx_outst_cnt != '0);

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_cnt   = spu_pcx_outst_cnt;
        case (state)
            IDLE: if (can_grant) next_state = REQ;
            REQ:  if (lsu_spu_ldst_ack) next_state = can_grant ? REQ : IDLE;
            default: next_state = IDLE;
        endcase
        if (can_grant)
            next_ptr = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        case ({can_grant, ret_eff})
            2'b10:   next_cnt = spu_pcx_outst_cnt + 1'b1;
            2'b01:   next_cnt = spu_pcx_outst_cnt - 1'b1;
            default: next_cnt = spu_pcx_outst_cnt;
        endcase
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            ptr               <= '0;
            spu_pcx_outst_cnt <= '0;
            spu_pcx_busy      <= 1'b0;
        end else begin
            state             <= next_state;
            ptr               <= next_ptr;
            spu_pcx_outst_cnt <= next_cnt;
            spu_pcx_busy      <= (next_state == REQ) || (next_cnt != '0);
        end
    end

`ifdef SPU_PCX_TIMEOUT_EN
    logic [7:0] wdog;
    logic       wdog_run;

    assign wdog_run = (state == REQ) && !lsu_spu_ldst_ack;

    // Flag is set on the same edge the watchdog reaches 255 and never clears until reset.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            wdog            <= '0;
            spu_pcx_timeout <= 1'b0;
        end else begin
            if (!wdog_run)
                wdog <= '0;
            else if (wdog != 8'hff)
                wdog <= wdog + 1'b1;
            if (wdog_run && (wdog == 8'hfe))
                spu_pcx_timeout <= 1'b1;
        end
    end
`else
    assign spu_pcx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spu_pcx_req_ctl.sv
// Directed self-checking bench for spu_pcx_req_ctl: arbitration, credits, back-to-back, async reset, watchdog.
module tb_spu_pcx_req_ctl;

    logic       rclk = 1'b0;
    logic       reset;
    logic [3:0] spu_req_vld;
    logic [3:0] spu_req_grant;
    logic       spu_wen_pcx_wen;
    logic       spu_wen_pcx_7170_sel;
    logic       spu_lsu_ldst_req;
    logic       lsu_spu_ldst_ack;
    logic       lsu_spu_ldst_ret;
    logic [2:0] spu_pcx_outst_cnt;
    logic       spu_pcx_busy;
    logic       spu_pcx_timeout;

    int checks = 0;
    int errors = 0;

`ifdef SPU_PCX_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    spu_pcx_req_ctl #(.NREQ(4), .MAX_OUTST(4), .CNT_W(3)) dut (
        .rclk                 (rclk),
        .reset                (reset),
        .spu_req_vld          (spu_req_vld),
        .spu_req_grant        (spu_req_grant),
        .spu_wen_pcx_wen      (spu_wen_pcx_wen),
        .spu_wen_pcx_7170_sel (spu_wen_pcx_7170_sel),
        .spu_lsu_ldst_req     (spu_lsu_ldst_req),
        .lsu_spu_ldst_ack     (lsu_spu_ldst_ack),
        .lsu_spu_ldst_ret     (lsu_spu_ldst_ret),
        .spu_pcx_outst_cnt    (spu_pcx_outst_cnt),
        .spu_pcx_busy         (spu_pcx_busy),
        .spu_pcx_timeout      (spu_pcx_timeout)
    );

    always #5 rclk = ~rclk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        spu_req_vld      = 4'b0000;
        lsu_spu_ldst_ack = 1'b0;
        lsu_spu_ldst_ret = 1'b0;
        reset            = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        spu_req_vld      = 4'b0000;
        lsu_spu_ldst_ack = 1'b0;
        lsu_spu_ldst_ret = 1'b0;
        reset            = 1'b1;
        repeat (3) tick();
        checks++;
        if ({spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_lsu_ldst_req,
             spu_pcx_outst_cnt, spu_pcx_busy, spu_pcx_timeout} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got grant=%b wen=%b sel=%b req=%b cnt=%0d busy=%b to=%b expected all 0",
                     spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_lsu_ldst_req,
                     spu_pcx_outst_cnt, spu_pcx_busy, spu_pcx_timeout);
        end
        reset = 1'b0;
        #2;
        checks++;
        if (spu_lsu_ldst_req !== 1'b0 || spu_pcx_outst_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_release got req=%b cnt=%0d expected req=0 cnt=0",
                     spu_lsu_ldst_req, spu_pcx_outst_cnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        spu_req_vld = 4'b0101;
        #2;
        checks++;
        if (spu_req_grant !== 4'b0001 || spu_wen_pcx_wen !== 1'b1 || spu_wen_pcx_7170_sel !== 1'b1 || spu_lsu_ldst_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_grant0 got grant=%b wen=%b sel=%b req=%b expected 0001 1 1 0",
                     spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_lsu_ldst_req);
        end
        tick();
        checks++;
        if (spu_lsu_ldst_req !== 1'b1 || spu_req_grant !== 4'b0000 || spu_wen_pcx_wen !== 1'b0 ||
            spu_wen_pcx_7170_sel !== 1'b0 || spu_pcx_outst_cnt !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rr_wait_ack got req=%b grant=%b wen=%b sel=%b cnt=%0d expected 1 0000 0 0 1",
                     spu_lsu_ldst_req, spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_pcx_outst_cnt);
        end
        lsu_spu_ldst_ack = 1'b1;
        #1;
        checks++;
        if (spu_req_grant !== 4'b0100 || spu_wen_pcx_wen !== 1'b1 || spu_wen_pcx_7170_sel !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_grant2 got grant=%b wen=%b sel=%b expected 0100 1 1",
                     spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel);
        end
        tick();
        #1;
        checks++;
        if (spu_req_grant !== 4'b0001 || spu_lsu_ldst_req !== 1'b1 || spu_pcx_outst_cnt !== 3'd2) begin
            errors++;
            $display("[TB] FAIL rr_grant0_again got grant=%b req=%b cnt=%0d expected 0001 1 2",
                     spu_req_grant, spu_lsu_ldst_req, spu_pcx_outst_cnt);
        end
        tick();
        spu_req_vld = 4'b0000;
        #1;
        checks++;
        if (spu_req_grant !== 4'b0000 || spu_lsu_ldst_req !== 1'b1 || spu_pcx_outst_cnt !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rr_last_ack got grant=%b req=%b cnt=%0d expected 0000 1 3",
                     spu_req_grant, spu_lsu_ldst_req, spu_pcx_outst_cnt);
        end
        tick();
        lsu_spu_ldst_ack = 1'b0;
        checks++;
        if (spu_lsu_ldst_req !== 1'b0 || spu_pcx_busy !== 1'b1 || spu_pcx_outst_cnt !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rr_idle got req=%b busy=%b cnt=%0d expected 0 1 3",
                     spu_lsu_ldst_req, spu_pcx_busy, spu_pcx_outst_cnt);
        end
        lsu_spu_ldst_ret = 1'b1;
        for (int k = 2; k >= -1; k--) begin
            tick();
            checks++;
            if (spu_pcx_outst_cnt !== 3'((k < 0) ? 0 : k)) begin
                errors++;
                $display("[TB] FAIL ret_drain got cnt=%0d expected %0d", spu_pcx_outst_cnt, (k < 0) ? 0 : k);
            end
        end
        lsu_spu_ldst_ret = 1'b0;
        checks++;
        if (spu_pcx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_clear got busy=%b expected 0", spu_pcx_busy);
        end
    endtask

    task automatic test_credit_limit();
        logic [3:0] exp_g;
        do_reset();
        spu_req_vld      = 4'b1111;
        lsu_spu_ldst_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_g = 4'b0001 << c;
            #2;
            checks++;
            if (spu_req_grant !== exp_g) begin
                errors++;
                $display("[TB] FAIL credit_grant%0d got %b expected %b", c, spu_req_grant, exp_g);
            end
            tick();
            checks++;
            if (spu_pcx_outst_cnt !== 3'(c + 1)) begin
                errors++;
                $display("[TB] FAIL credit_cnt%0d got %0d expected %0d", c, spu_pcx_outst_cnt, c + 1);
            end
        end
        #2;
        checks++;
        if (spu_req_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL credit_block got grant=%b expected 0000", spu_req_grant);
        end
        tick();
        checks++;
        if (spu_lsu_ldst_req !== 1'b0 || spu_pcx_outst_cnt !== 3'd4 || spu_req_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL credit_full got req=%b cnt=%0d grant=%b expected 0 4 0000",
                     spu_lsu_ldst_req, spu_pcx_outst_cnt, spu_req_grant);
        end
        lsu_spu_ldst_ret = 1'b1;
        #1;
        checks++;
        if (spu_req_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL credit_ret_same_cycle got grant=%b expected 0000", spu_req_grant);
        end
        tick();
        lsu_spu_ldst_ret = 1'b0;
        #1;
        checks++;
        if (spu_pcx_outst_cnt !== 3'd3 || spu_req_grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL credit_regrant got cnt=%0d grant=%b expected 3 0001",
                     spu_pcx_outst_cnt, spu_req_grant);
        end
        tick();
        checks++;
        if (spu_pcx_outst_cnt !== 3'd4) begin
            errors++;
            $display("[TB] FAIL credit_refill got cnt=%0d expected 4", spu_pcx_outst_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        spu_req_vld = 4'b0001;
        #2;
        checks++;
        if (spu_req_grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL b2b_first got grant=%b expected 0001", spu_req_grant);
        end
        tick();
        lsu_spu_ldst_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            lsu_spu_ldst_ret = (c == 1);
            #1;
            checks++;
            if (spu_req_grant !== 4'b0001 || spu_lsu_ldst_req !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_grant%0d got grant=%b req=%b expected 0001 1", c, spu_req_grant, spu_lsu_ldst_req);
            end
            tick();
            checks++;
            if (spu_lsu_ldst_req !== 1'b1 || spu_pcx_outst_cnt !== 3'd2) begin
                errors++;
                $display("[TB] FAIL b2b_cnt%0d got req=%b cnt=%0d expected 1 2", c, spu_lsu_ldst_req, spu_pcx_outst_cnt);
            end
        end
        spu_req_vld      = 4'b0000;
        lsu_spu_ldst_ret = 1'b0;
        tick();
        lsu_spu_ldst_ack = 1'b0;
        checks++;
        if (spu_lsu_ldst_req !== 1'b0 || spu_pcx_outst_cnt !== 3'd2) begin
            errors++;
            $display("[TB] FAIL b2b_end got req=%b cnt=%0d expected 0 2", spu_lsu_ldst_req, spu_pcx_outst_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        spu_req_vld = 4'b1000;
        tick();
        lsu_spu_ldst_ack = 1'b1;
        repeat (2) tick();
        lsu_spu_ldst_ack = 1'b0;
        spu_req_vld      = 4'b1111;
        checks++;
        if (spu_lsu_ldst_req !== 1'b1 || spu_pcx_outst_cnt !== 3'd3) begin
            errors++;
            $display("[TB] FAIL arst_setup got req=%b cnt=%0d expected 1 3", spu_lsu_ldst_req, spu_pcx_outst_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_lsu_ldst_req,
             spu_pcx_outst_cnt, spu_pcx_busy, spu_pcx_timeout} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL arst_outputs got grant=%b wen=%b sel=%b req=%b cnt=%0d busy=%b to=%b expected all 0",
                     spu_req_grant, spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_lsu_ldst_req,
                     spu_pcx_outst_cnt, spu_pcx_busy, spu_pcx_timeout);
        end
        tick();
        reset       = 1'b0;
        spu_req_vld = 4'b1010;
        #2;
        checks++;
        if (spu_req_grant !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL arst_ptr got grant=%b expected 0010", spu_req_grant);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        spu_req_vld = 4'b0001;
        tick();
        spu_req_vld = 4'b0000;
        repeat (254) tick();
        checks++;
        if (spu_pcx_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early got %b expected 0", spu_pcx_timeout);
        end
        tick();
        checks++;
        if (spu_pcx_timeout !== EXP_TO) begin
            errors++;
            $display("[TB] FAIL timeout_rise got %b expected %b", spu_pcx_timeout, EXP_TO);
        end
        repeat (45) tick();
        lsu_spu_ldst_ack = 1'b1;
        tick();
        lsu_spu_ldst_ack = 1'b0;
        tick();
        checks++;
        if (spu_pcx_timeout !== EXP_TO || spu_lsu_ldst_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky got to=%b req=%b expected %b 0",
                     spu_pcx_timeout, spu_lsu_ldst_req, EXP_TO);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spu_pcx_req_ctl.md
Name: spu_pcx_req_ctl

Overview:
- Arbitration and sequencing controller for the SPU-to-LSU PCX request packet register and its fast bank-select bypass path.
- Selects one of NREQ SPU request sources (MA load, MA store, stream ops) with a round-robin policy.
- Drives the packet-register write enable (spu_wen_pcx_wen) and the bank-select bits [71:70] bypass select (spu_wen_pcx_7170_sel).
- Holds the request valid to the LSU until acknowledged, and enforces an outstanding-request credit limit.

Parameters:
- NREQ, 4, number of request sources.
- MAX_OUTST, 4, maximum requests issued but not yet returned.
- CNT_W, 3, width of the outstanding counter; must hold MAX_OUTST.

Ports:
- rclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- spu_req_vld  in  NREQ  per-source request level; held until granted.
- spu_req_grant  out  NREQ  one-hot grant, 1-cycle pulse; the source's packet is muxed onto spu_ldstreq_pcx in this same cycle.
- spu_wen_pcx_wen  out  1  packet-register capture enable.
- spu_wen_pcx_7170_sel  out  1  1 = bank bits [71:70] taken live; 0 = bank bits taken from the flopped copy.
- spu_lsu_ldst_req  out  1  packet valid to the LSU.
- lsu_spu_ldst_ack  in  1  LSU accepted the current packet.
- lsu_spu_ldst_ret  in  1  completion return; releases one credit.
- spu_pcx_outst_cnt  out  CNT_W  current outstanding-request count.
- spu_pcx_busy  out  1  high when state is REQ or spu_pcx_outst_cnt != 0.
- spu_pcx_timeout  out  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, state = IDLE, round-robin pointer = 0, outstanding counter = 0. Reset asserted mid-operation aborts any pending request immediately, with no ack required.
- Grant condition (can_grant): any spu_req_vld bit set AND spu_pcx_outst_cnt < MAX_OUTST AND (state == IDLE OR (state == REQ AND lsu_spu_ldst_ack)).
- Arbitration: search starts at the pointer index and wraps modulo NREQ; the first requesting source wins. After a grant, pointer = winner + 1, wrapping from NREQ-1 to 0. The pointer does not change when there is no grant.
- Grant cycle:
  - spu_req_grant[winner] = 1, spu_wen_pcx_wen = 1, spu_wen_pcx_7170_sel = 1.
  - Next state = REQ.
  - Counter increments.
- State REQ:
  - spu_lsu_ldst_req = 1; spu_wen_pcx_wen = 0 unless a back-to-back grant occurs.
  - On lsu_spu_ldst_ack with can_grant true: issue a new grant in the same cycle and stay in REQ, giving zero-bubble back-to-back issue.
  - On lsu_spu_ldst_ack without a grant: go to IDLE; spu_lsu_ldst_req drops the next cycle.
- lsu_spu_ldst_ack while in IDLE is ignored.
- spu_wen_pcx_7170_sel is 1 only in grant cycles and 0 at all other times.
- Counter rules:
  - Grant and lsu_spu_ldst_ret in the same cycle: count unchanged.
  - Return only: decrement; a return when the count is 0 is ignored and the count stays 0.
  - Count == MAX_OUTST blocks new grants; a return in that cycle does not unblock a grant until the following cycle, since the credit check uses the registered count.
- All outputs are registered except spu_req_grant, spu_wen_pcx_wen and spu_wen_pcx_7170_sel, which are combinational from registered state and the inputs.

Optional Feature:
- Macro: SPU_PCX_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog increments each cycle in REQ without an ack, and clears on ack or when leaving REQ.
  - When the watchdog reaches 255, spu_pcx_timeout is set.
  - spu_pcx_timeout is sticky until reset; it does not alter the FSM.
- When undefined: no watchdog logic; spu_pcx_timeout is tied to 0.

Test Plan:
- Reset, then spu_req_vld = 4'b0101 held:
  - Grants in order: src0, then src2 after the ack, then src0.
  - spu_wen_pcx_wen and spu_wen_pcx_7170_sel pulse high in each grant cycle.
  - spu_lsu_ldst_req is high from each grant+1 until its ack.
- All 4 sources requesting, LSU acks every cycle and never returns:
  - Exactly 4 grants (cnt 1..4), then grants stop and spu_pcx_outst_cnt = 4.
  - One lsu_spu_ldst_ret yields cnt 3, and the next grant comes one cycle later.
- Ack coincident with a pending request in REQ: new grant in the same cycle, spu_lsu_ldst_req stays continuously high, no idle cycle.
- Grant and ret in the same cycle with cnt = 2: cnt stays 2. A ret with cnt = 0 leaves cnt at 0.
- Reset asserted asynchronously while in REQ with cnt = 3: all outputs go to 0 without waiting for a clock edge; after release, a src3 request is granted first only if no lower index is requesting (pointer = 0).
- With SPU_PCX_TIMEOUT_EN, ack withheld for 300 cycles: spu_pcx_timeout rises 255 cycles after entering REQ and stays 1 after a later ack. Without the macro it stays 0.
